call_stack_unit: RTL and testbench

Hardware stack for the pipelined RISC core: the responder to the decoder's `push`/`pop` control pair. It stores return addresses for CALL and register operands for PUSH, and returns them for RET and POP. It sits beside the execute/memory stage and keeps its own pointer, occupancy count and full/empty status. Pop data is registered so the writeback and PC-select paths see a stable value one cycle after the request.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/stack_mem.sv | 34 +++
 rtl/call_stack_unit.sv | 136 +++++++++++++
 tb/tb_call_stack_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared core constants: datapath width, stack opcodes, word type.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_CALL = 6'b001101;
  localparam logic [5:0] OP_RET  = 6'b001110;
  localparam logic [5:0] OP_PUSH = 6'b001111;
  localparam logic [5:0] OP_POP  = 6'b010000;

  typedef logic [WORD_W-1:0] word_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// ============================================================================
// Module   : stack_mem
// Purpose  : DEPTH x WORD_W register array, one sync write port and one
//            async read port. Contents are not reset.
// Revision : 1.0
// ============================================================================
module stack_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WORD_W = cpu_pkg::WORD_W,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : stack_mem
`default_nettype wire

// File: rtl/call_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : call_stack_unit
// Purpose  : Hardware return-address / operand stack with registered pop data.
//            Optional sticky overflow/underflow flags under CALL_STACK_ERR_EN.
// Revision : 1.0
// ============================================================================
module call_stack_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WORD_W = cpu_pkg::WORD_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WORD_W-1:0]          push_data,
  output logic [WORD_W-1:0]          pop_data,
  output logic                       pop_valid,
  output logic [WORD_W-1:0]          top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
`ifdef CALL_STACK_ERR_EN
  ,
  input  logic                       clr_err,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     r_sp;
  logic [CW-1:0]     r_count;
  logic [WORD_W-1:0] r_pop_data;
  logic              r_pop_valid;

  logic              w_empty;
  logic              w_full;
  logic [AW-1:0]     w_sp_m1;
  logic              w_pop_ok;
  logic              w_replace;
  logic              w_push_ok;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [WORD_W-1:0] w_rd_data;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_sp_m1   = r_sp - AW'(1);

  // A pop with data available wins; a simultaneous push then overwrites the top.
  assign w_pop_ok  = pop & ~w_empty;
  assign w_replace = push & w_pop_ok;
  assign w_push_ok = push & ~w_pop_ok & ~w_full;
  assign w_we      = w_replace | w_push_ok;
  assign w_waddr   = w_replace ? w_sp_m1 : r_sp;

  stack_mem #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .AW     (AW)
  ) u_stack_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (push_data),
    .raddr (w_sp_m1),
    .rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp        <= '0;
      r_count     <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
    end else begin
      r_pop_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_pop_data <= w_rd_data;
      end
      if (w_push_ok) begin
        r_sp    <= r_sp + AW'(1);
        r_count <= r_count + CW'(1);
      end else if (w_pop_ok && !push) begin
        r_sp    <= w_sp_m1;
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign top       = w_empty ? '0 : w_rd_data;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;

`ifdef CALL_STACK_ERR_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_evt;
  logic w_udf_evt;

  assign w_ovf_evt = push & ~pop & w_full;
  assign w_udf_evt = pop & w_empty;

  // A new error in the same cycle as clr_err leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_udf_evt) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule : call_stack_unit
`default_nettype wire

// File: tb/tb_call_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_call_stack_unit
// Purpose  : Directed + randomized bench for call_stack_unit against a
//            queue-based stack model.
// Revision : 1.0
// ============================================================================
module tb_call_stack_unit;

  localparam int DEPTH  = 8;
  localparam int WORD_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [WORD_W-1:0] push_data = '0;
  logic [WORD_W-1:0] pop_data;
  logic              pop_valid;
  logic [WORD_W-1:0] top;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              clr_err = 1'b0;
`ifdef CALL_STACK_ERR_EN
  logic              overflow;
  logic              underflow;
`endif

  call_stack_unit #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full)
`ifdef CALL_STACK_ERR_EN
    ,
    .clr_err   (clr_err),
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a plain queue, back of the queue is the top of stack.
  logic [WORD_W-1:0] m_q[$];
  logic [WORD_W-1:0] m_pop_data = '0;
  logic              m_pop_valid = 1'b0;
  logic              m_ovf = 1'b0;
  logic              m_udf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pop_data  = '0;
    m_pop_valid = 1'b0;
    m_ovf       = 1'b0;
    m_udf       = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic o, input logic [WORD_W-1:0] d, input logic c);
    logic new_ovf = 1'b0;
    logic new_udf = 1'b0;
    m_pop_valid = 1'b0;
    if (o && m_q.size() > 0) begin
      m_pop_data  = m_q[m_q.size()-1];
      m_pop_valid = 1'b1;
      if (p) m_q[m_q.size()-1] = d;
      else   void'(m_q.pop_back());
    end else begin
      if (o) new_udf = 1'b1;
      if (p) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else                    new_ovf = 1'b1;
      end
    end
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (new_ovf) m_ovf = 1'b1;
    if (new_udf) m_udf = 1'b1;
  endtask

  task automatic check_all(input string tag);
    logic [WORD_W-1:0] exp_top;
    exp_top = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
    check({tag, ".count"},     64'(count),     64'(m_q.size()));
    check({tag, ".empty"},     64'(empty),     64'(m_q.size() == 0));
    check({tag, ".full"},      64'(full),      64'(m_q.size() == DEPTH));
    check({tag, ".top"},       64'(top),       64'(exp_top));
    check({tag, ".pop_valid"}, 64'(pop_valid), 64'(m_pop_valid));
    check({tag, ".pop_data"},  64'(pop_data),  64'(m_pop_data));
`ifdef CALL_STACK_ERR_EN
    check({tag, ".overflow"},  64'(overflow),  64'(m_ovf));
    check({tag, ".underflow"}, 64'(underflow), 64'(m_udf));
`endif
  endtask

  // One clock of stimulus; outputs sampled 1 time unit after the edge.
  task automatic step(input string tag, input logic p, input logic o,
                      input logic [WORD_W-1:0] d, input logic c);
    @(negedge clk);
    push = p; pop = o; push_data = d; clr_err = c;
    model_step(p, o, d, c);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Three pushes then three pops: LIFO order, one-cycle pop latency.
    step("push10", 1'b1, 1'b0, 32'h10, 1'b0);
    step("push20", 1'b1, 1'b0, 32'h20, 1'b0);
    step("push30", 1'b1, 1'b0, 32'h30, 1'b0);
    check("tp1.top_is_30", 64'(top), 64'h30);
    step("pop30", 1'b0, 1'b1, '0, 1'b0);
    check("tp2.pop_data_30", 64'(pop_data), 64'h30);
    step("pop20", 1'b0, 1'b1, '0, 1'b0);
    step("pop10", 1'b0, 1'b1, '0, 1'b0);
    check("tp2.pop_data_10", 64'(pop_data), 64'h10);
    idle("after_pops");

    // Fill, then an extra push while full is dropped.
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, WORD_W'(i), 1'b0);
    step("push_full", 1'b1, 1'b0, 32'h99, 1'b0);
    check("tp3.top_is_8", 64'(top), 64'h8);
    step("pop_after_full", 1'b0, 1'b1, '0, 1'b0);
    check("tp3.pop_data_8", 64'(pop_data), 64'h8);
    // Replace-top while full.
    for (int i = 0; i < 1; i++) step("refill", 1'b1, 1'b0, 32'h77, 1'b0);
    step("replace_full", 1'b1, 1'b1, 32'h66, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, '0, 1'b0);

    // Underflow then clear; push+pop while empty acts as a push.
    step("pop_empty", 1'b0, 1'b1, '0, 1'b0);
    step("clr_err", 1'b0, 1'b0, '0, 1'b1);
    step("pushpop_empty", 1'b1, 1'b1, 32'h44, 1'b0);
    step("pop44", 1'b0, 1'b1, '0, 1'b0);
    step("udf_and_clr", 1'b0, 1'b1, '0, 1'b1);

    // Replace-top.
    step("pushA", 1'b1, 1'b0, 32'hA, 1'b0);
    step("replaceB", 1'b1, 1'b1, 32'hB, 1'b0);
    check("tp5.pop_data_A", 64'(pop_data), 64'hA);
    check("tp5.top_B", 64'(top), 64'hB);

    // Asynchronous reset mid-cycle while a pop result is showing.
    step("push5", 1'b1, 1'b0, 32'h5, 1'b0);
    step("pop_before_rst", 1'b0, 1'b1, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("pop_after_rst", 1'b0, 1'b1, '0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic p, o, c;
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 8);
      step("rand", p, o, WORD_W'($urandom), c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_call_stack_unit
`default_nettype wire
